clk_strobe_gen: RTL and testbench

Parametrised multi-channel clock divider and strobe generator that replaces the fixed single-divisor square-wave divider used for slow clocks around the `apple1` core (PS/2 clock, simulation pacing, peripheral ticks). Each of `NUM_CH` channels has a runtime-programmable divisor and mode: square wave, single-cycle strobe, or fractional NCO. New divisors are staged and applied glitch-free at the channel's terminal count. All logic runs in the `clk25` domain.

---
 rtl/clk_strobe_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_clk_strobe_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_strobe_gen.sv
// Multi-channel clock divider / strobe generator for the clk25 domain.
// Each channel runs as a square-wave divider, a single-cycle strobe
// generator or a fractional NCO. New settings are staged in a shadow
// register and only copied into the active set at a safe point (terminal
// count, NCO carry, sync, disable or HOLD), so a divisor change never
// produces a runt or stretched pulse.

module clk_strobe_ch #(
  parameter int CNT_W    = 28,
  parameter int DEF_DIV  = 2,
  parameter int DEF_MODE = 0
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             ch_en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  output logic             cfg_pend,
  output logic             clk_out,
  output logic             stb_out
);

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_NCO    = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [1:0]       DEF_MODE_C = 2'(DEF_MODE);

  // A divisor of 0 behaves like 1 so the counter always has a terminal count.
  function automatic logic [CNT_W-1:0] div_eff_f(input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] r;
    if (d == ZERO_C) begin
      r = ONE_C;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Output clock level for a given mode, divisor and counter value.
  // SQUARE is low for the first half (rounded down) of the period, so odd
  // divisors get the longer high phase.
  function automatic logic clk_level_f(
    input logic [1:0]       m,
    input logic [CNT_W-1:0] d,
    input logic [CNT_W-1:0] cnt,
    input logic             stb
  );
    logic r;
    case (m)
      MODE_SQUARE: r = (cnt >= (div_eff_f(d) >> 1));
      MODE_PULSE:  r = stb;
      MODE_NCO:    r = cnt[CNT_W-1];
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  // Registered state
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] sh_div_r;
  logic [1:0]       sh_mode_r;
  logic             pend_r;
  logic             clk_r;
  logic             stb_r;

  // Next-state values
  logic [CNT_W-1:0] cnt_nx_s;
  logic [CNT_W-1:0] div_nx_s;
  logic [1:0]       mode_nx_s;
  logic [CNT_W-1:0] sh_div_nx_s;
  logic [1:0]       sh_mode_nx_s;
  logic             pend_nx_s;
  logic             clk_nx_s;
  logic             stb_nx_s;

  // Intermediate decode
  logic [CNT_W-1:0] new_div_s;
  logic [1:0]       new_mode_s;
  logic             wrap_s;
  logic [CNT_W:0]   sum_s;
  logic             carry_s;
  logic             apply_s;
  logic             tick_s;
  logic             quiet_s;

  // A write in the same cycle as an apply point bypasses the shadow.
  assign new_div_s  = wr_hit ? cfg_div  : sh_div_r;
  assign new_mode_s = wr_hit ? cfg_mode : sh_mode_r;

  // ">=" rather than "==" so a counter left beyond a shrunken divisor
  // recovers on the very next edge.
  assign wrap_s  = (cnt_r >= (div_eff_f(div_r) - ONE_C));
  assign sum_s   = {1'b0, cnt_r} + {1'b0, div_r};
  assign carry_s = sum_s[CNT_W];

  // Counter / accumulator advance and apply-point detection.
  always_comb begin
    cnt_nx_s = cnt_r;
    apply_s  = 1'b0;
    tick_s   = 1'b0;
    quiet_s  = 1'b0;
    if (!ch_en) begin
      cnt_nx_s = ZERO_C;
      apply_s  = 1'b1;
      quiet_s  = 1'b1;
    end else if (sync) begin
      cnt_nx_s = ZERO_C;
      apply_s  = 1'b1;
    end else begin
      case (mode_r)
        MODE_SQUARE, MODE_PULSE: begin
          if (wrap_s) begin
            cnt_nx_s = ZERO_C;
            apply_s  = 1'b1;
            tick_s   = 1'b1;
          end else begin
            cnt_nx_s = cnt_r + ONE_C;
          end
        end
        MODE_NCO: begin
          // Without a pending change the accumulator keeps its fractional
          // remainder across a carry; with one it restarts from zero.
          if (carry_s && (pend_r || wr_hit)) begin
            cnt_nx_s = ZERO_C;
            apply_s  = 1'b1;
            tick_s   = 1'b1;
          end else begin
            cnt_nx_s = sum_s[CNT_W-1:0];
            tick_s   = carry_s;
          end
        end
        default: begin
          cnt_nx_s = ZERO_C;
          apply_s  = 1'b1;
        end
      endcase
    end
  end

  // Active / shadow configuration and pending flag update.
  always_comb begin
    sh_div_nx_s  = new_div_s;
    sh_mode_nx_s = new_mode_s;
    if (apply_s) begin
      div_nx_s  = new_div_s;
      mode_nx_s = new_mode_s;
      pend_nx_s = 1'b0;
    end else if (wr_hit) begin
      div_nx_s  = div_r;
      mode_nx_s = mode_r;
      pend_nx_s = 1'b1;
    end else begin
      div_nx_s  = div_r;
      mode_nx_s = mode_r;
      pend_nx_s = pend_r;
    end
  end

  // Output levels derived from the next counter value and next config.
  always_comb begin
    if (quiet_s || (mode_nx_s == MODE_HOLD)) begin
      clk_nx_s = 1'b0;
      stb_nx_s = 1'b0;
    end else begin
      stb_nx_s = tick_s;
      clk_nx_s = clk_level_f(mode_nx_s, div_nx_s, cnt_nx_s, tick_s);
    end
  end

  // Channel state and output flops.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= ZERO_C;
      div_r     <= DEF_DIV_C;
      mode_r    <= DEF_MODE_C;
      sh_div_r  <= DEF_DIV_C;
      sh_mode_r <= DEF_MODE_C;
      pend_r    <= 1'b0;
      clk_r     <= 1'b0;
      stb_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      div_r     <= div_nx_s;
      mode_r    <= mode_nx_s;
      sh_div_r  <= sh_div_nx_s;
      sh_mode_r <= sh_mode_nx_s;
      pend_r    <= pend_nx_s;
      clk_r     <= clk_nx_s;
      stb_r     <= stb_nx_s;
    end
  end

  assign cfg_pend = pend_r;
  assign clk_out  = clk_r;
  assign stb_out  = stb_r;

endmodule

module clk_strobe_gen #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 28,
  parameter int DEF_DIV  = 2,
  parameter int DEF_MODE = 0
) (
  input  logic                                          clk25,
  input  logic                                          rst_n,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  input  logic [1:0]                                    cfg_mode,
  input  logic [NUM_CH-1:0]                             ch_en,
  input  logic                                          sync,
  output logic [NUM_CH-1:0]                             cfg_pend,
  output logic [NUM_CH-1:0]                             clk_out,
  output logic [NUM_CH-1:0]                             stb_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_hit_s;

    // Channel indices at or above NUM_CH match no channel and are dropped.
    assign wr_hit_s = cfg_we && (cfg_ch == CH_W'(c));

    clk_strobe_ch #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_MODE (DEF_MODE)
    ) u_ch (
      .clk25    (clk25),
      .rst_n    (rst_n),
      .ch_en    (ch_en[c]),
      .sync     (sync),
      .wr_hit   (wr_hit_s),
      .cfg_div  (cfg_div),
      .cfg_mode (cfg_mode),
      .cfg_pend (cfg_pend[c]),
      .clk_out  (clk_out[c]),
      .stb_out  (stb_out[c])
    );
  end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Scoreboard bench for clk_strobe_gen: stimulus pushes expected output
// samples (keyed by sample time) into a queue, a monitor compares them.

module tb_clk_strobe_gen;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;

  // Instance A: 4 channels, 28-bit counters
  logic        a_cfg_we;
  logic [1:0]  a_cfg_ch;
  logic [27:0] a_cfg_div;
  logic [1:0]  a_cfg_mode;
  logic [3:0]  a_ch_en;
  logic        a_sync;
  logic [3:0]  a_cfg_pend, a_clk_out, a_stb_out;

  // Instance B: 3 channels, 8-bit accumulator for NCO checks
  logic        b_cfg_we;
  logic [1:0]  b_cfg_ch;
  logic [7:0]  b_cfg_div;
  logic [1:0]  b_cfg_mode;
  logic [2:0]  b_ch_en;
  logic        b_sync;
  logic [2:0]  b_cfg_pend, b_clk_out, b_stb_out;

  clk_strobe_gen #(.NUM_CH(4), .CNT_W(28), .DEF_DIV(2), .DEF_MODE(0)) u_a (
    .clk25(clk25), .rst_n(rst_n), .cfg_we(a_cfg_we), .cfg_ch(a_cfg_ch),
    .cfg_div(a_cfg_div), .cfg_mode(a_cfg_mode), .ch_en(a_ch_en), .sync(a_sync),
    .cfg_pend(a_cfg_pend), .clk_out(a_clk_out), .stb_out(a_stb_out)
  );

  clk_strobe_gen #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(2), .DEF_MODE(0)) u_b (
    .clk25(clk25), .rst_n(rst_n), .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch),
    .cfg_div(b_cfg_div), .cfg_mode(b_cfg_mode), .ch_en(b_ch_en), .sync(b_sync),
    .cfg_pend(b_cfg_pend), .clk_out(b_clk_out), .stb_out(b_stb_out)
  );

  typedef struct {
    time   t;
    int    inst;
    int    ch;
    logic  c;
    logic  s;
    logic  p;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  // Sample time just after rising edge number n (edge n at 10n-5).
  function automatic time edge_t(input int n);
    return time'(10 * n - 4);
  endfunction

  function automatic logic [2:0] dut_bits(input int inst, input int ch);
    logic [1:0] idx;
    idx = ch[1:0];
    if (inst == 0) return {a_clk_out[idx], a_stb_out[idx], a_cfg_pend[idx]};
    else           return {b_clk_out[idx], b_stb_out[idx], b_cfg_pend[idx]};
  endfunction

  task automatic push(input time t, input int inst, input int ch,
                      input logic c, input logic s, input logic p, input string name);
    exp_t e;
    e.t = t; e.inst = inst; e.ch = ch; e.c = c; e.s = s; e.p = p; e.name = name;
    sb.push_back(e);
  endtask

  // Expected samples for a SQUARE/PULSE/HOLD run; p0 is the counter value
  // seen after the first checked edge.
  task automatic exp_run(input int inst, input int ch, input int first, input int div,
                         input int mode, input int p0, input int n, input string name);
    int   de, half, p;
    logic es, ec;
    de   = (div < 1) ? 1 : div;
    half = de / 2;
    for (int i = 0; i < n; i++) begin
      p  = (p0 + i) % de;
      es = (p == 0);
      if (mode == 0)      ec = (p >= half);
      else if (mode == 1) ec = es;
      else                ec = 1'b0;
      if (mode == 3) es = 1'b0;
      push(edge_t(first + i), inst, ch, ec, es, 1'b0, name);
    end
  endtask

  // Monitor: compare every expectation due at this sample point.
  always @(posedge clk25 or negedge rst_n) begin
    logic [2:0] act;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t < $time) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s ch%0d: sample missed (due %0t, now %0t)", sb[i].name, sb[i].ch, sb[i].t, $time);
        sb.delete(i);
      end else if (sb[i].t == $time) begin
        act = dut_bits(sb[i].inst, sb[i].ch);
        n_vec++;
        if (act !== {sb[i].c, sb[i].s, sb[i].p}) begin
          n_bad++;
          $display("FAIL %s inst%0d ch%0d @%0t: got clk=%0b stb=%0b pend=%0b, want clk=%0b stb=%0b pend=%0b",
                   sb[i].name, sb[i].inst, sb[i].ch, $time, act[2], act[1], act[0],
                   sb[i].c, sb[i].s, sb[i].p);
        end
        sb.delete(i);
      end
    end
  end

  // Disable all A channels, write config (applied at once), then run it.
  task automatic a_run(input int ch, input int div, input int mode, input int n, input string name);
    a_ch_en    = 4'b0000;
    a_cfg_we   = 1'b1;
    a_cfg_ch   = 2'(ch);
    a_cfg_div  = 28'(div);
    a_cfg_mode = 2'(mode);
    push(edge_t(cyc + 1), 0, ch, 1'b0, 1'b0, 1'b0, {name, "_apply"});
    @(negedge clk25);
    a_cfg_we = 1'b0;
    a_ch_en  = 4'b0001 << ch;
    exp_run(0, ch, cyc + 1, div, mode, 1, n, name);
    repeat (n) @(negedge clk25);
  endtask

  task automatic b_prog(input int ch, input int div, input int mode);
    b_ch_en    = 3'b000;
    b_cfg_we   = 1'b1;
    b_cfg_ch   = 2'(ch);
    b_cfg_div  = 8'(div);
    b_cfg_mode = 2'(mode);
    push(edge_t(cyc + 1), 1, ch, 1'b0, 1'b0, 1'b0, "b_apply");
    @(negedge clk25);
    b_cfg_we = 1'b0;
    b_ch_en  = 3'b001 << ch;
  endtask

  initial begin
    int         c;
    logic [0:3] c64, s64;
    logic [0:7] c96, s96;
    c64 = 4'b0110; s64 = 4'b0001;
    c96 = 8'b01011010; s96 = 8'b00100101;

    a_cfg_we = 1'b0; a_cfg_ch = 2'd0; a_cfg_div = 28'd0; a_cfg_mode = 2'd0;
    a_ch_en = 4'b0000; a_sync = 1'b0;
    b_cfg_we = 1'b0; b_cfg_ch = 2'd0; b_cfg_div = 8'd0; b_cfg_mode = 2'd0;
    b_ch_en = 3'b000; b_sync = 1'b0;

    // Held in reset for two edges: everything zero.
    for (int n = 1; n <= 2; n++) begin
      for (int ch = 0; ch < 4; ch++) push(edge_t(n), 0, ch, 1'b0, 1'b0, 1'b0, "reset");
      push(edge_t(n), 1, 0, 1'b0, 1'b0, 1'b0, "reset_b");
    end
    @(negedge clk25);
    @(negedge clk25);

    // Defaults (div 2, SQUARE): clk toggles, strobe every 2nd cycle.
    rst_n   = 1'b1;
    a_ch_en = 4'b0001;
    exp_run(0, 0, cyc + 1, 2, 0, 1, 8, "def_div2");
    push(edge_t(cyc + 1), 0, 1, 1'b0, 1'b0, 1'b0, "ch1_idle");
    repeat (8) @(negedge clk25);

    a_run(0, 5, 0, 15, "div5");
    a_run(2, 1000, 0, 2000, "div1000");
    a_run(3, 0, 0, 4, "div0");
    a_run(3, 1, 0, 4, "div1");
    a_run(3, 3, 1, 9, "pulse3");
    a_run(3, 4, 3, 4, "hold");

    // Mid-period write: div 100 at cnt 40, then div 10.
    a_run(1, 100, 0, 40, "div100");
    a_cfg_we = 1'b1; a_cfg_ch = 2'd1; a_cfg_div = 28'd10; a_cfg_mode = 2'd0;
    c = cyc;
    for (int i = 0; i < 59; i++) push(edge_t(c + 1 + i), 0, 1, ((41 + i) >= 50), 1'b0, 1'b1, "midwr_pend");
    push(edge_t(c + 60), 0, 1, 1'b0, 1'b1, 1'b0, "midwr_wrap");
    exp_run(0, 1, c + 61, 10, 0, 1, 20, "div10");
    @(negedge clk25);
    a_cfg_we = 1'b0;
    repeat (79) @(negedge clk25);

    // Sync: channels 0/1 at div 6/9.
    a_ch_en = 4'b0000; a_cfg_we = 1'b1; a_cfg_mode = 2'd0;
    a_cfg_ch = 2'd0; a_cfg_div = 28'd6;
    @(negedge clk25);
    a_cfg_ch = 2'd1; a_cfg_div = 28'd9;
    @(negedge clk25);
    a_cfg_we = 1'b0; a_ch_en = 4'b0011;
    exp_run(0, 0, cyc + 1, 6, 0, 1, 7, "free6");
    exp_run(0, 1, cyc + 1, 9, 0, 1, 7, "free9");
    repeat (7) @(negedge clk25);
    a_sync = 1'b1;
    c = cyc;
    push(edge_t(c + 1), 0, 0, 1'b0, 1'b0, 1'b0, "sync_edge0");
    push(edge_t(c + 1), 0, 1, 1'b0, 1'b0, 1'b0, "sync_edge1");
    @(negedge clk25);
    a_sync = 1'b0;
    exp_run(0, 0, c + 2, 6, 0, 1, 18, "sync6");
    exp_run(0, 1, c + 2, 9, 0, 1, 18, "sync9");
    repeat (18) @(negedge clk25);

    // Async reset mid-period with a pending write.
    a_run(2, 20, 0, 14, "div20");
    a_cfg_we = 1'b1; a_cfg_ch = 2'd2; a_cfg_div = 28'd7; a_cfg_mode = 2'd0;
    c = cyc;
    push(edge_t(c + 1), 0, 2, 1'b1, 1'b0, 1'b1, "pend_rise");
    push(edge_t(c + 2), 0, 2, 1'b1, 1'b0, 1'b1, "pend_hold");
    @(negedge clk25);
    a_cfg_we = 1'b0;
    @(negedge clk25);
    #2;
    push($time + 1, 0, 2, 1'b0, 1'b0, 1'b0, "rst_async");
    rst_n = 1'b0;
    push(edge_t(cyc + 1), 0, 2, 1'b0, 1'b0, 1'b0, "rst_hold");
    @(negedge clk25);
    rst_n = 1'b1;
    exp_run(0, 2, cyc + 1, 2, 0, 1, 4, "rst_defaults");
    repeat (4) @(negedge clk25);

    // NCO, 8-bit: div 64 -> tick every 4 cycles.
    b_prog(0, 64, 2);
    c = cyc;
    for (int i = 0; i < 12; i++) push(edge_t(c + 1 + i), 1, 0, c64[i % 4], s64[i % 4], 1'b0, "nco64");
    repeat (12) @(negedge clk25);

    // NCO div 96 -> 3 ticks per 8; write to channel 3 (absent) is ignored.
    b_prog(0, 96, 2);
    b_cfg_we = 1'b1; b_cfg_ch = 2'd3; b_cfg_div = 8'd5; b_cfg_mode = 2'd1;
    c = cyc;
    for (int i = 0; i < 16; i++) push(edge_t(c + 1 + i), 1, 0, c96[i % 8], s96[i % 8], 1'b0, "nco96");
    for (int k = 1; k <= 2; k++) begin
      push(edge_t(c + k), 1, 1, 1'b0, 1'b0, 1'b0, "badch_1");
      push(edge_t(c + k), 1, 2, 1'b0, 1'b0, 1'b0, "badch_2");
    end
    @(negedge clk25);
    b_cfg_we = 1'b0;
    repeat (15) @(negedge clk25);

    // NCO div 0 never ticks.
    b_prog(0, 0, 2);
    for (int i = 1; i <= 4; i++) push(edge_t(cyc + i), 1, 0, 1'b0, 1'b0, 1'b0, "nco0");
    repeat (4) @(negedge clk25);

    repeat (2) @(negedge clk25);
    while (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s ch%0d: never sampled (due %0t)", sb[0].name, sb[0].ch, sb[0].t);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
